// File: rtl/fir_pkg.sv
// Shared constants, output-state encoding and the weighted-sum helper
// for the time-shared 5-tap FIR scheduler.
package fir_pkg;

  localparam int TAPS = 5;

  localparam logic signed [31:0] W0 = 32'sd1;
  localparam logic signed [31:0] W1 = 32'sd2;
  localparam logic signed [31:0] W2 = 32'sd4;
  localparam logic signed [31:0] W3 = 32'sd2;
  localparam logic signed [31:0] W4 = 32'sd1;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Weighted sum in 32-bit two's complement; the caller keeps the low result
  // bits, which wrap exactly as a signalSize+4 bit adder truncated would.
  function automatic logic signed [31:0] fir_sum(
    input logic signed [31:0] x,
    input logic signed [31:0] h3,
    input logic signed [31:0] h2,
    input logic signed [31:0] h1,
    input logic signed [31:0] h0
  );
    return x * W0 + h3 * W1 + h2 * W2 + h1 * W3 + h0 * W4;
  endfunction

endpackage

// File: rtl/fir_channel_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (cyclically) wins,
// reported both one-hot and encoded.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic              enable,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_any
);

  logic [CH_W:0]   scan_sum;
  logic [CH_W-1:0] cand;

  // Scan candidates ptr, ptr+1, ... and latch onto the first active request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_sum  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_sum = {1'b0, ptr} + (CH_W+1)'(i);
      if (scan_sum >= (CH_W+1)'(NUM_CH)) begin
        scan_sum = scan_sum - (CH_W+1)'(NUM_CH);
      end else begin
        scan_sum = scan_sum;
      end
      cand = scan_sum[CH_W-1:0];
      if (enable && !grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/fir_channel_scheduler.sv
// One shared 5-tap low-pass FIR (1,2,4,2,1) time-multiplexed over NUM_CH
// streams, each with its own tap history and prime counter.
module fir_channel_scheduler
  import fir_pkg::*;
#(
  parameter int signalSize = 8,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*signalSize-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH-1:0]            flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [signalSize-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_primed
);

  localparam int HIST = TAPS - 1;

  logic [NUM_CH-1:0][HIST-1:0][signalSize-1:0] hist_q, hist_d;
  logic [NUM_CH-1:0][2:0]                      prime_q, prime_d;
  logic [CH_W-1:0]                             ptr_q, ptr_d;
  state_e                                      state_q, state_d;
  logic [signalSize-1:0]                       out_data_q, out_data_d;
  logic [CH_W-1:0]                             out_ch_q, out_ch_d;
  logic                                        out_primed_q, out_primed_d;

  logic                                        can_issue;
  logic [NUM_CH-1:0]                           gnt;
  logic [CH_W-1:0]                             gnt_idx;
  logic                                        gnt_any;
  logic [signalSize-1:0]                       sample;
  logic [HIST-1:0][signalSize-1:0]             g_hist;
  logic [2:0]                                  g_prime;

  assign can_issue  = (state_q == EMPTY) || out_ready;
  assign in_ready   = rst ? gnt : '0;
  assign out_valid  = (state_q == FULL);
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign out_primed = out_primed_q;

  rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req       (in_valid),
    .enable    (can_issue),
    .ptr       (ptr_q),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  // Next-state for histories, prime counts, pointer, output register and FSM.
  always_comb begin
    hist_d       = hist_q;
    prime_d      = prime_q;
    ptr_d        = ptr_q;
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_primed_d = out_primed_q;

    sample  = in_data[gnt_idx*signalSize +: signalSize];
    // A flush coinciding with an accept filters against an already-cleared history.
    g_hist  = flush[gnt_idx] ? '0 : hist_q[gnt_idx];
    g_prime = flush[gnt_idx] ? 3'd0 : prime_q[gnt_idx];

    for (int c = 0; c < NUM_CH; c++) begin
      if (flush[c]) begin
        hist_d[c]  = '0;
        prime_d[c] = 3'd0;
      end else begin
        hist_d[c]  = hist_d[c];
      end
    end

    if (gnt_any) begin
      hist_d[gnt_idx]  = {sample, g_hist[HIST-1:1]};
      prime_d[gnt_idx] = (g_prime >= 3'd5) ? 3'd5 : g_prime + 3'd1;
      out_data_d       = signalSize'(fir_sum(32'(signed'(sample)),
                                             32'(signed'(g_hist[3])),
                                             32'(signed'(g_hist[2])),
                                             32'(signed'(g_hist[1])),
                                             32'(signed'(g_hist[0]))));
      out_ch_d         = gnt_idx;
      out_primed_d     = (g_prime >= 3'd4);
      ptr_d            = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end else begin
      ptr_d = ptr_q;
    end

    case (state_q)
      EMPTY:   state_d = gnt_any ? FULL : EMPTY;
      FULL: begin
        if (out_ready) begin
          state_d = gnt_any ? FULL : EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q       <= '0;
      prime_q      <= '0;
      ptr_q        <= '0;
      state_q      <= EMPTY;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_primed_q <= 1'b0;
    end else begin
      hist_q       <= hist_d;
      prime_q      <= prime_d;
      ptr_q        <= ptr_d;
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_primed_q <= out_primed_d;
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed and randomized bench for fir_channel_scheduler against a
// sample-window reference model.
module tb_fir_channel_scheduler;

  localparam int NCH = 4;
  localparam int SW  = 8;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    in_valid;
  logic [NCH*SW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic [NCH-1:0]    flush;
  logic              out_valid;
  logic              out_ready;
  logic [SW-1:0]     out_data;
  logic [1:0]        out_ch;
  logic              out_primed;

  fir_channel_scheduler #(.signalSize(SW), .NUM_CH(NCH), .CH_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_primed (out_primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel list of samples since the last flush/reset.
  logic [SW-1:0] smp [NCH];
  int            hq  [NCH][$];
  int            ns  [NCH];
  int            wt  [5] = '{1, 2, 4, 2, 1};
  int            mptr;
  logic          exp_valid;
  logic [SW-1:0] exp_data;
  logic [1:0]    exp_ch;
  logic          exp_primed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_valid  = 1'b0;
    exp_data   = '0;
    exp_ch     = '0;
    exp_primed = 1'b0;
    mptr       = 0;
    for (int c = 0; c < NCH; c++) begin
      hq[c].delete();
      ns[c] = 0;
    end
  endtask

  // One clock: predict grant, check in_ready, advance model, check registered outputs.
  task automatic tick();
    int g;
    int x;
    int s;
    int c;
    logic [NCH-1:0] er;
    for (int k = 0; k < NCH; k++) in_data[k*SW +: SW] = smp[k];
    #1;
    g = -1;
    if (!exp_valid || out_ready) begin
      for (int i = 0; i < NCH; i++) begin
        c = (mptr + i) % NCH;
        if (g < 0 && in_valid[c]) g = c;
      end
    end
    er = (g >= 0) ? NCH'(1 << g) : '0;
    chk("in_ready", 32'(in_ready), 32'(er));
    for (int k = 0; k < NCH; k++) begin
      if (flush[k]) begin
        hq[k].delete();
        ns[k] = 0;
      end
    end
    if (g >= 0) begin
      x = int'($signed(smp[g]));
      s = x;
      for (int k = 1; k <= 4; k++) begin
        if (hq[g].size() >= k) s += wt[k] * hq[g][hq[g].size() - k];
      end
      exp_data   = SW'(s);
      exp_ch     = 2'(g);
      exp_primed = (ns[g] >= 4);
      exp_valid  = 1'b1;
      hq[g].push_back(x);
      if (hq[g].size() > 4) void'(hq[g].pop_front());
      ns[g]++;
      mptr = (g + 1) % NCH;
    end else if (!exp_valid || out_ready) begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("out_data", 32'(out_data), 32'(exp_data));
      chk("out_ch", 32'(out_ch), 32'(exp_ch));
      chk("out_primed", 32'(out_primed), 32'(exp_primed));
    end
    @(negedge clk);
  endtask

  logic [SW-1:0] imp_exp  [6] = '{8'd1, 8'd2, 8'd4, 8'd2, 8'd1, 8'd0};
  logic [SW-1:0] wrap_exp [6] = '{8'd100, 8'd44, 8'hBC, 8'h84, 8'hE8, 8'hE8};
  int            pat      [6] = '{1, 3, 7, 9, 10, 10};

  initial begin
    rst       = 1'b0;
    in_valid  = '1;
    in_data   = '0;
    flush     = '0;
    out_ready = 1'b1;
    for (int c = 0; c < NCH; c++) smp[c] = '0;
    model_reset();

    // Reset state, with every channel requesting.
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_primed", 32'(out_primed), 32'd0);
    in_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Impulse on channel 0.
    in_valid = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      smp[0] = (i == 0) ? 8'd1 : 8'd0;
      tick();
      chk("imp_data", 32'(out_data), 32'(imp_exp[i]));
      chk("imp_primed", 32'(out_primed), 32'(i >= 4));
    end

    // Reset asserted while a result is held.
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // All channels busy with constant c+1.
    in_valid = 4'b1111;
    for (int c = 0; c < NCH; c++) smp[c] = SW'(c + 1);
    for (int i = 0; i < 24; i++) begin
      tick();
      chk("rr_ch", 32'(out_ch), 32'(i % NCH));
      chk("rr_data", 32'(out_data),
          32'(SW'(((i % NCH) + 1) * pat[(i / NCH) > 5 ? 5 : (i / NCH)])));
    end

    // Backpressure while full, then release.
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (8) tick();

    // Wrap on channel 1 with constant 100.
    in_valid = 4'b0010;
    smp[1]   = 8'd100;
    for (int i = 0; i < 6; i++) begin
      flush = (i == 0) ? 4'b0010 : 4'b0000;
      tick();
      chk("wrap_data", 32'(out_data), 32'(wrap_exp[i]));
    end
    flush = '0;

    // Flush coinciding with an accept on channel 2.
    in_valid = 4'b0100;
    smp[2]   = 8'd10;
    for (int i = 0; i < 5; i++) begin
      flush = (i == 0) ? 4'b0100 : 4'b0000;
      tick();
    end
    smp[2] = 8'd7;
    flush  = 4'b0100;
    tick();
    chk("flush_data", 32'(out_data), 32'd7);
    chk("flush_primed", 32'(out_primed), 32'd0);
    flush = '0;
    tick();
    chk("post_flush_data", 32'(out_data), 32'd21);

    // Randomized traffic, backpressure and flushes.
    for (int i = 0; i < 400; i++) begin
      in_valid  = NCH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NCH; c++) begin
        smp[c]   = SW'($urandom);
        flush[c] = ($urandom_range(0, 15) == 0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_channel_scheduler.md
Name: fir_channel_scheduler

Overview:
Time-shares one 5-tap low-pass FIR datapath (weights 1,2,4,2,1) across NUM_CH independent sample streams.
- Each channel keeps its own tap history.
- A round-robin arbiter picks one channel's sample per cycle, runs it through the shared weighted sum, and registers the result with the channel tag.
- The block sits between the per-channel sample sources and the downstream consumer, replacing one filter instance per channel.

Parameters:
- signalSize, 8, sample and result width in bits (signed two's complement).
- NUM_CH, 4, number of channels (2..16).
- CH_W, 2, channel-index width; must equal ceil(log2(NUM_CH)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  NUM_CH  per-channel sample valid.
- in_data  input  NUM_CH*signalSize  packed samples; channel c is bits [c*signalSize +: signalSize].
- in_ready  output  NUM_CH  one-hot grant; sample c is accepted when in_valid[c] and in_ready[c] are both high.
- flush  input  NUM_CH  per-channel clear of tap history and prime count.
- out_valid  output  1  result register holds data.
- out_ready  input  1  consumer accepts the result.
- out_data  output  signalSize  filtered sample.
- out_ch  output  CH_W  channel the result belongs to.
- out_primed  output  1  result was computed from 5 real samples since the last reset or flush.

Behaviour:
- Reset (rst low, asynchronous): all history regs 0, all prime counts 0, rr pointer 0, FSM EMPTY.
  - out_valid 0, out_data 0, out_ch 0, out_primed 0.
  - in_ready is 0 while rst is low.
- Per-channel state:
  - History H[c][0..3] holds the previous four samples, H[c][3] newest.
  - Prime count P[c] is a 3-bit counter saturating at 5.
- Output FSM states: EMPTY and FULL.
  - can_issue = (state==EMPTY) || out_ready.
  - EMPTY: if any in_valid, grant and go to FULL; otherwise stay in EMPTY.
  - FULL with out_ready=1: if any in_valid, grant and stay FULL (back-to-back); otherwise go to EMPTY and drop out_valid.
  - FULL with out_ready=0: hold. out_data, out_ch and out_primed stay stable, in_ready is all 0, no history changes.
- Arbitration:
  - Only when can_issue. Grant the first c with in_valid[c], scanning ptr, ptr+1, ... modulo NUM_CH.
  - in_ready = one-hot of the grant. It is combinational from in_valid, the FSM state and out_ready. in_valid never depends on in_ready.
  - On a grant g, ptr <= (g+1) mod NUM_CH. With no grant, ptr is unchanged.
- On an accepted sample x from channel g:
  - y = x + 2*H[g][3] + 4*H[g][2] + 2*H[g][1] + H[g][0].
  - The sum is computed at signalSize+4 bits, then truncated to the low signalSize bits (modulo wrap, no saturation).
  - At the clock edge: out_data<=y, out_ch<=g, out_valid<=1, out_primed<=(P[g]>=4).
  - History shifts: H[g][0]<=H[g][1] ... H[g][3]<=x. P[g]<=min(P[g]+1,5).
- Latency: 1 cycle from accept to out_valid. Throughput is 1 sample/cycle aggregate while out_ready stays high.
- flush[c] alone: at the next edge, H[c] is zeroed and P[c] is 0. An already-registered result is unaffected.
- flush[c] together with an accept on c in the same cycle:
  - The sample is filtered against a zeroed history, so y = x and out_primed = 0.
  - Afterwards H[c] = {0,0,0,x} and P[c] = 1.
- Non-granted channels: history and count are never touched.
- Reset asserted mid-operation: the in-flight result is discarded and all state returns to its reset values immediately.

Decomposition:
- Package fir_pkg holds:
  - TAPS=5 and tap weight constants W0..W4 = 1,2,4,2,1.
  - FSM state encoding (EMPTY, FULL).
  - Function fir_sum(x, h3, h2, h1, h0) returning the truncated weighted sum.
- Sub-module rr_arbiter (parameter NUM_CH): inputs req, enable, ptr; output one-hot grant plus the encoded index.
- The top module holds the history and prime-count arrays, the output register, the FSM and the pointer update.

Test Plan:
- Reset: rst low then high with no valid → out_valid=0, in_ready=0, out_data=0; asserting rst mid-stream clears out_valid in the same cycle.
- Impulse on ch0, out_ready=1: samples 1,0,0,0,0,0 → out_data 1,2,4,2,1,0 on consecutive cycles, out_ch=0; out_primed=1 from the 5th result onward.
- All 4 channels valid continuously, ch c sends the constant c+1:
  - grants rotate 0,1,2,3,0,...
  - ch c's results are (c+1)×{1,3,7,9,10,10,...}, e.g. ch3 gives 4,12,28,36,40,40.
- Backpressure: hold out_ready=0 for 3 cycles while FULL → out_data and out_ch stable, in_ready=0, no history change; after release the sequence resumes with no lost or duplicated sample.
- Wrap: ch1 constant 100 (signalSize=8) → out_data 100, 44, -68, -124, -24, then -24 steady.
- Flush: ch2 is primed with 5 samples of 10; on the next accept of x=7 with flush[2]=1, expect out_data=7 and out_primed=0; the following sample x=7 gives 21.
